// File: rtl/series_sum_engine.sv
// -----------------------------------------------------------------------------
// series_sum_engine
//
// Sums f(k) for k = lo..hi (inclusive), one term per clock, where f(k) is
// selected by mode: k, k^2, k^3, or k-if-odd-else-0. The sum wraps modulo
// 2^S_W and a sticky ovf flag records any carry out of the accumulator.
//
// Ports
//   clk     in   1      rising-edge clock
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      request a new computation (accepted in IDLE or DONE)
//   mode    in   2      term function select
//   lo      in   N_W    first index, unsigned
//   hi      in   N_W    last index, unsigned, inclusive
//   busy    out  1      high while terms are being accumulated
//   done    out  1      one-cycle pulse: result/ovf are valid
//   result  out  S_W    sum modulo 2^S_W, held until the next accepted start
//   ovf     out  1      sticky carry-out flag for the current run
//
// S_W must be at least 3*N_W so that a single cube term always fits.
// -----------------------------------------------------------------------------
module series_sum_engine #(
  parameter int N_W = 8,
  parameter int S_W = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     mode,
  input  logic [N_W-1:0] lo,
  input  logic [N_W-1:0] hi,
  output logic           busy,
  output logic           done,
  output logic [S_W-1:0] result,
  output logic           ovf
);

  localparam int T_W = 3 * N_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [1:0]     mode_q;
  logic [N_W-1:0] hi_q;
  logic [N_W-1:0] k_q;
  logic [S_W-1:0] acc_q;
  logic           ovf_q;
  logic           busy_q;
  logic           done_q;

  logic [T_W-1:0] term_w;
  logic [S_W:0]   acc_d;

  // Term evaluated at full 3*N_W width so k^3 is exact for every index.
  function automatic logic [T_W-1:0] term_f(input logic [1:0]     m,
                                            input logic [N_W-1:0] k);
    logic [T_W-1:0] kx;
    kx = T_W'(k);
    case (m)
      2'b00:   term_f = kx;
      2'b01:   term_f = kx * kx;
      2'b10:   term_f = kx * kx * kx;
      default: term_f = k[0] ? kx : '0;
    endcase
  endfunction

  // Wrapping add; the extra top bit is the carry that feeds the sticky flag.
  function automatic logic [S_W:0] acc_add_f(input logic [S_W-1:0] a,
                                             input logic [T_W-1:0] t);
    acc_add_f = {1'b0, a} + (S_W+1)'(t);
  endfunction

  always_comb begin
    term_w = term_f(mode_q, k_q);
    acc_d  = acc_add_f(acc_q, term_w);
  end

  // Operand capture: only on an accepted start, so input changes during RUN
  // are invisible to the running computation.
  always_ff @(posedge clk) begin
    if (start && (state_q != RUN)) begin
      mode_q <= mode;
      hi_q   <= hi;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (start) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            k_q   <= lo;
            if (lo <= hi) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end else begin
              // Empty range: report zero on the very next cycle.
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          acc_q <= acc_d[S_W-1:0];
          ovf_q <= ovf_q | acc_d[S_W];
          // Test for the last index before incrementing, so hi at the top
          // of the index range never wraps k.
          if (k_q == hi_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = acc_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_series_sum_engine.sv
// -----------------------------------------------------------------------------
// tb_series_sum_engine
//
// Directed bench for series_sum_engine with hand-computed expected sums,
// done timing, busy duration, reset behaviour and back-to-back runs.
// -----------------------------------------------------------------------------
module tb_series_sum_engine;

  localparam int N_W = 8;
  localparam int S_W = 24;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [1:0]     mode;
  logic [N_W-1:0] lo;
  logic [N_W-1:0] hi;
  logic           busy;
  logic           done;
  logic [S_W-1:0] result;
  logic           ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  series_sum_engine #(.N_W(N_W), .S_W(S_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mode   (mode),
    .lo     (lo),
    .hi     (hi),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Leaves the bench at the falling edge just after the start edge.
  task automatic pulse_start(input logic [1:0] m, input int l, input int h);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    lo    = N_W'(l);
    hi    = N_W'(h);
    @(negedge clk);
    start = 1'b0;
  endtask

  // c = index of the cycle (1 = first after the start edge) whose sample
  // shows done; 0 if done never arrives within the budget.
  task automatic wait_done(output int c, output int nb);
    c  = 0;
    nb = 0;
    for (int i = 1; i <= 600; i++) begin
      if (done === 1'b1) begin
        c = i;
        break;
      end
      if (busy === 1'b1) nb++;
      @(negedge clk);
    end
  endtask

  task automatic run_check(input string tag, input logic [1:0] m,
                           input int l, input int h,
                           input int exp_res, input int exp_ovf,
                           input int exp_c, input int exp_busy);
    int c;
    int nb;
    pulse_start(m, l, h);
    wait_done(c, nb);
    chk({tag, " done_cycle"}, 32'(c), 32'(exp_c));
    chk({tag, " busy_cycles"}, 32'(nb), 32'(exp_busy));
    chk({tag, " result"}, 32'(result), 32'(exp_res));
    chk({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
    @(negedge clk);
    chk({tag, " done_pulse_end"}, 32'(done), 32'd0);
    chk({tag, " idle_busy"}, 32'(busy), 32'd0);
    chk({tag, " result_hold"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    int c;
    int nb;
    int seen;

    rst_n = 1'b0;
    start = 1'b0;
    mode  = 2'b00;
    lo    = '0;
    hi    = '0;
    #12;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_check("sum_1_10",   2'b00, 1, 10,  55, 0, 11, 10);
    run_check("sq_1_10",    2'b01, 1, 10, 385, 0, 11, 10);
    run_check("cube_1_4",   2'b10, 1, 4,  100, 0,  5,  4);
    run_check("odd_3_9",    2'b11, 3, 9,   24, 0,  8,  7);
    run_check("empty_7_3",  2'b00, 7, 3,    0, 0,  1,  0);
    run_check("cube_255",   2'b10, 255, 255, 16581375, 0, 2, 1);
    run_check("cube_1_255", 2'b10, 1, 255, 8404992, 1, 256, 255);
    run_check("sum_ovf_clr", 2'b00, 1, 10, 55, 0, 11, 10);

    // Reset in the middle of a long run.
    pulse_start(2'b00, 1, 100);
    repeat (19) @(negedge clk);
    chk("midrun busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async busy", 32'(busy), 32'd0);
    chk("async done", 32'(done), 32'd0);
    chk("async result", 32'(result), 32'd0);
    chk("async ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      @(negedge clk);
    end
    chk("aborted no activity", 32'(seen), 32'd0);
    run_check("after_rst_0_0", 2'b00, 0, 0, 0, 0, 2, 1);

    // Start pulse and operand changes during RUN must be ignored; then a
    // second run is launched from the DONE cycle.
    pulse_start(2'b00, 1, 10);
    c = 0;
    for (int i = 1; i <= 40; i++) begin
      if (done === 1'b1) begin
        c = i;
        break;
      end
      if (i == 4) begin
        start = 1'b1;
        mode  = 2'b10;
        lo    = 8'd0;
        hi    = 8'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b first done_cycle", 32'(c), 32'd11);
    chk("b2b first result", 32'(result), 32'd55);
    start = 1'b1;
    mode  = 2'b01;
    lo    = 8'd5;
    hi    = 8'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(c, nb);
    chk("b2b second done_cycle", 32'(c), 32'd2);
    chk("b2b second busy_cycles", 32'(nb), 32'd1);
    chk("b2b second result", 32'(result), 32'd25);
    chk("b2b second ovf", 32'(ovf), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
